// File: rtl/custom_counter_pkg.sv
// Shared types and constants for the custom countdown counter and its sequencer.
package custom_counter_pkg;

  localparam int unsigned CFG_WIDTH = 2;

  // Period selections understood by the countdown counter (50 MHz clock).
  localparam logic [CFG_WIDTH-1:0] CFG_0P5S = 2'd0;
  localparam logic [CFG_WIDTH-1:0] CFG_1S   = 2'd1;
  localparam logic [CFG_WIDTH-1:0] CFG_1P5S = 2'd2;
  localparam logic [CFG_WIDTH-1:0] CFG_2S   = 2'd3;

  // The counter powers up with the 1 s period.
  localparam logic [CFG_WIDTH-1:0] DEFAULT_CFG = CFG_1S;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/custom_counter_sequencer.sv
// Sequencer that programs, arms and re-arms the countdown counter for a run of laps.
module custom_counter_sequencer
  import custom_counter_pkg::*;
#(
  parameter int unsigned LAP_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CFG_WIDTH-1:0] config_in,
  input  logic [LAP_WIDTH-1:0] num_laps,
  input  logic                 counter_expire,
  input  logic                 irq_ack,
  output logic                 load,
  output logic [CFG_WIDTH-1:0] load_config,
  output logic                 reset_counter,
  output logic [LAP_WIDTH-1:0] lap_count,
  output logic                 busy,
  output logic                 done,
  output logic                 irq
);

  seq_state_t           state_q, state_d;
  logic [LAP_WIDTH-1:0] limit_q, limit_d;
  logic [LAP_WIDTH-1:0] lap_count_q, lap_count_d;
  logic [CFG_WIDTH-1:0] load_config_q, load_config_d;
  logic                 load_q, load_d;
  logic                 reset_counter_q, reset_counter_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 irq_q, irq_d;
  logic                 irq_set;
  logic [LAP_WIDTH-1:0] lap_inc;

  // Next-state and registered-output logic.
  // S_ARM spans two cycles: it raises reset_counter, then moves to S_RUN only
  // once the counter has sampled the strobe, so a stale expiry still present
  // while the counter reloads is never seen in S_RUN.
  always_comb begin
    state_d         = state_q;
    limit_d         = limit_q;
    lap_count_d     = lap_count_q;
    load_config_d   = load_config_q;
    load_d          = 1'b0;
    reset_counter_d = 1'b0;
    done_d          = done_q;
    irq_set         = 1'b0;
    lap_inc         = lap_count_q + LAP_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d       = S_LOAD;
          load_config_d = config_in;
          limit_d       = num_laps;
          lap_count_d   = '0;
          done_d        = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          load_d  = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (reset_counter_q) begin
          state_d = S_RUN;
        end else begin
          reset_counter_d = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (counter_expire) begin
          lap_count_d = lap_inc;
          if ((limit_q != '0) && (lap_inc == limit_q)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            irq_set = 1'b1;
          end else begin
            state_d = S_ARM;
            irq_set = (limit_q == '0);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_ARM) || (state_d == S_RUN);

    // A new interrupt takes priority over an acknowledge in the same cycle.
    irq_d = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if (irq_set) irq_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      limit_q         <= '0;
      lap_count_q     <= '0;
      load_config_q   <= DEFAULT_CFG;
      load_q          <= 1'b0;
      reset_counter_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      limit_q         <= limit_d;
      lap_count_q     <= lap_count_d;
      load_config_q   <= load_config_d;
      load_q          <= load_d;
      reset_counter_q <= reset_counter_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      irq_q           <= irq_d;
    end
  end

  assign load          = load_q;
  assign load_config   = load_config_q;
  assign reset_counter = reset_counter_q;
  assign lap_count     = lap_count_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_custom_counter_sequencer.sv
// Randomized and directed bench for custom_counter_sequencer against a timeline reference model.
module tb_custom_counter_sequencer;

  localparam int unsigned LAP_WIDTH = 8;

  logic                 clock = 1'b0;
  logic                 resetn = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [1:0]           config_in = 2'd0;
  logic [LAP_WIDTH-1:0] num_laps = '0;
  logic                 counter_expire = 1'b0;
  logic                 irq_ack = 1'b0;
  logic                 load;
  logic [1:0]           load_config;
  logic                 reset_counter;
  logic [LAP_WIDTH-1:0] lap_count;
  logic                 busy;
  logic                 done;
  logic                 irq;

  custom_counter_sequencer #(.LAP_WIDTH(LAP_WIDTH)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .abort          (abort),
    .config_in      (config_in),
    .num_laps       (num_laps),
    .counter_expire (counter_expire),
    .irq_ack        (irq_ack),
    .load           (load),
    .load_config    (load_config),
    .reset_counter  (reset_counter),
    .lap_count      (lap_count),
    .busy           (busy),
    .done           (done),
    .irq            (irq)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a timeline measured in edges since the last arming event.
  bit                   m_active, m_first, m_done_pend;
  int                   m_since;
  logic [LAP_WIDTH-1:0] m_lap, m_limit;
  logic [1:0]           m_cfg;
  bit                   m_done, m_irq, m_load, m_rc, m_busy;

  // Countdown counter stand-in: expiry sticks until the counter sees reset_counter.
  bit c_exp, prev_rc, rand_period;
  int c_cnt, c_period;

  // Event tallies for the directed scenarios.
  int n_load, n_rc, n_irq;
  bit irq_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_first = 0; m_done_pend = 0; m_since = 0;
    m_lap = '0; m_limit = '0; m_cfg = 2'd1;
    m_done = 0; m_irq = 0; m_load = 0; m_rc = 0; m_busy = 0;
  endtask

  task automatic model_edge();
    bit irq_set, was_pend, live;
    irq_set = 0;
    was_pend = m_done_pend;
    m_done_pend = 0;
    if (m_active) begin
      if (abort) begin
        m_active = 0;
      end else begin
        // Expiry only counts once the arming strobe has been consumed by the counter.
        live = m_since >= (m_first ? 3 : 2);
        m_since++;
        if (live && counter_expire) begin
          m_lap = m_lap + 8'd1;
          if (m_limit != 0 && m_lap == m_limit) begin
            m_active = 0; m_done = 1; irq_set = 1; m_done_pend = 1;
          end else begin
            if (m_limit == 0) irq_set = 1;
            m_since = 0; m_first = 0;
          end
        end
      end
    end else if (!was_pend && start && !abort) begin
      m_active = 1; m_first = 1; m_since = 0;
      m_cfg = config_in; m_limit = num_laps; m_lap = '0; m_done = 0;
    end
    m_irq  = irq_set ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
    m_busy = m_active;
    m_load = m_active && m_first && m_since == 1;
    m_rc   = m_active && (m_first ? (m_since == 2) : (m_since == 1));
  endtask

  task automatic check_all();
    chk("load", 32'(load), 32'(m_load));
    chk("load_config", 32'(load_config), 32'(m_cfg));
    chk("reset_counter", 32'(reset_counter), 32'(m_rc));
    chk("lap_count", 32'(lap_count), 32'(m_lap));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic counter_reset();
    c_exp = 0; c_cnt = 0; prev_rc = 0; counter_expire = 1'b0;
  endtask

  // One clock: model the edge, compare, then advance the counter stand-in.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
    if (load) n_load++;
    if (reset_counter) n_rc++;
    if (irq && !irq_prev) n_irq++;
    irq_prev = irq;
    if (prev_rc) begin
      c_exp = 0;
      c_cnt = rand_period ? $urandom_range(1, 6) : c_period;
    end else if (c_cnt > 0) begin
      c_cnt--;
      if (c_cnt == 0) c_exp = 1;
    end
    counter_expire = c_exp;
    prev_rc = reset_counter;
  endtask

  task automatic do_reset();
    start = 1'($urandom); abort = 1'($urandom); irq_ack = 1'($urandom);
    config_in = 2'($urandom); num_laps = 8'($urandom);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    resetn = 1'b1;
    start = 0; abort = 0; irq_ack = 0;
    counter_reset();
    irq_prev = 0;
  endtask

  initial begin
    model_reset();
    counter_reset();
    c_period = 20; rand_period = 0; irq_prev = 0;
    n_load = 0; n_rc = 0; n_irq = 0;

    // Reset with random inputs applied.
    start = 1'($urandom); abort = 1'($urandom); irq_ack = 1'($urandom);
    config_in = 2'($urandom); num_laps = 8'($urandom); counter_expire = 1'($urandom);
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    resetn = 1'b1;
    start = 0; abort = 0; irq_ack = 0; counter_expire = 0;
    repeat (2) cycle();

    // Three-lap run with period 1.5 s.
    config_in = 2'd2; num_laps = 8'd3; n_load = 0; n_rc = 0;
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 300 && !done; i++) cycle();
    chk("three_lap_done", 32'(done), 32'd1);
    chk("three_lap_irq", 32'(irq), 32'd1);
    chk("three_lap_busy", 32'(busy), 32'd0);
    chk("three_lap_count", 32'(lap_count), 32'd3);
    chk("three_lap_cfg", 32'(load_config), 32'd2);
    chk("three_lap_loads", 32'(n_load), 32'd1);
    chk("three_lap_arms", 32'(n_rc), 32'd3);
    repeat (3) cycle();

    // Continuous mode: acknowledge every interrupt.
    irq_ack = 1; cycle(); irq_ack = 0;
    config_in = 2'd0; num_laps = 8'd0; n_irq = 0;
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 600 && lap_count != 8'd5; i++) begin
      irq_ack = irq;
      cycle();
    end
    irq_ack = 0;
    chk("cont_laps", 32'(lap_count), 32'd5);
    chk("cont_irqs", 32'(n_irq), 32'd5);
    chk("cont_busy", 32'(busy), 32'd1);
    chk("cont_done", 32'(done), 32'd0);
    irq_ack = 1; abort = 1; cycle(); irq_ack = 0; abort = 0;
    chk("cont_abort_busy", 32'(busy), 32'd0);
    repeat (2) cycle();

    // Stale expiry held through LOAD/ARM, then abort after one lap.
    c_exp = 1; c_cnt = 0; counter_expire = 1;
    config_in = 2'd3; num_laps = 8'd3;
    start = 1; cycle(); start = 0;
    repeat (8) cycle();
    chk("stale_laps", 32'(lap_count), 32'd0);
    for (int i = 0; i < 100 && lap_count != 8'd1; i++) cycle();
    repeat (3) cycle();
    n_load = 0;
    start = 1; abort = 1; cycle(); start = 0; abort = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (30) cycle();
    chk("abort_laps", 32'(lap_count), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_irq", 32'(irq), 32'd0);
    chk("abort_no_load", 32'(n_load), 32'd0);

    // Collisions: start while busy, ack coincident with the final expiry.
    config_in = 2'd1; num_laps = 8'd1; n_load = 0;
    start = 1; cycle(); start = 0;
    repeat (5) cycle();
    start = 1; cycle(); start = 0;
    irq_ack = 1;
    for (int i = 0; i < 100 && !done; i++) cycle();
    chk("coll_irq", 32'(irq), 32'd1);
    chk("coll_done", 32'(done), 32'd1);
    chk("coll_one_load", 32'(n_load), 32'd1);
    cycle();
    irq_ack = 0;
    repeat (2) cycle();

    // Randomized traffic with short periods and occasional mid-run resets.
    rand_period = 1;
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      irq_ack   = ($urandom_range(0, 3) == 0);
      config_in = 2'($urandom);
      num_laps  = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end
    start = 0; abort = 0; irq_ack = 0;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
